// File: rtl/stream_compare_monitor.sv
// Compares a core output stream word-by-word against a golden stream,
// with optional byte reversal of the golden word, and records results.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, len, swap,
//   abort_on_fail       : run control, sampled when start is seen in IDLE
//   dut_out*            : stream under test (data, isReady, canReceive)
//   exp_in*             : golden stream (data, isReady, canReceive)
//   busy, done, fail    : run status (done is a one-cycle pulse)
//   mismatch_count      : saturating mismatch counter for the run
//   first_idx/got/exp   : details of the first mismatch of the run
module stream_compare_monitor #(
  parameter int WIDTH    = 64,
  parameter int LEN_BITS = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_BITS-1:0] len,
  input  logic                swap,
  input  logic                abort_on_fail,
  input  logic [WIDTH-1:0]    dut_out,
  input  logic                dut_out_isReady,
  output logic                dut_out_canReceive,
  input  logic [WIDTH-1:0]    exp_in,
  input  logic                exp_in_isReady,
  output logic                exp_in_canReceive,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [LEN_BITS-1:0] mismatch_count,
  output logic [LEN_BITS-1:0] first_idx,
  output logic [WIDTH-1:0]    first_got,
  output logic [WIDTH-1:0]    first_exp
);

  localparam int NB = WIDTH / 8;
  localparam logic [LEN_BITS-1:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                swap_q, swap_d;
  logic                abort_q, abort_d;
  logic [LEN_BITS-1:0] idx_q, idx_d;
  logic                fail_q, fail_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic [LEN_BITS-1:0] fidx_q, fidx_d;
  logic [WIDTH-1:0]    fgot_q, fgot_d;
  logic [WIDTH-1:0]    fexp_q, fexp_d;

  logic [WIDTH-1:0] exp_rev;
  logic [WIDTH-1:0] exp_cmp;
  logic             in_run;
  logic             xfer;
  logic             mis;
  logic             last;

  always_comb begin
    exp_rev = '0;
    for (int i = 0; i < NB; i++) begin
      exp_rev[i*8 +: 8] = exp_in[(NB-1-i)*8 +: 8];
    end
  end

  assign exp_cmp = swap_q ? exp_rev : exp_in;

`ifdef SYNTHESIS
  assign mis = (dut_out != exp_cmp);
`else
  assign mis = (dut_out !== exp_cmp);
`endif

  assign in_run = (state_q == RUN);
  // Each stream is only accepted when the other one is valid, so both
  // are consumed in lockstep without a combinational loop.
  assign dut_out_canReceive = in_run & exp_in_isReady;
  assign exp_in_canReceive  = in_run & dut_out_isReady;
  assign xfer = in_run & dut_out_isReady & exp_in_isReady;
  assign last = (idx_q == len_q - ONE);

  assign busy           = in_run;
  assign done           = (state_q == FIN);
  assign fail           = fail_q;
  assign mismatch_count = cnt_q;
  assign first_idx      = fidx_q;
  assign first_got      = fgot_q;
  assign first_exp      = fexp_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    swap_d  = swap_q;
    abort_d = abort_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q;
    fidx_d  = fidx_q;
    fgot_d  = fgot_q;
    fexp_d  = fexp_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          swap_d  = swap;
          abort_d = abort_on_fail;
          idx_d   = '0;
          fail_d  = 1'b0;
          cnt_d   = '0;
          fidx_d  = '0;
          fgot_d  = '0;
          fexp_d  = '0;
          state_d = (len == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          idx_d = idx_q + ONE;
          if (mis) begin
            fail_d = 1'b1;
            cnt_d  = (&cnt_q) ? cnt_q : cnt_q + ONE;
            // fail_q low means no mismatch yet in this run
            if (!fail_q) begin
              fidx_d = idx_q;
              fgot_d = dut_out;
              fexp_d = exp_cmp;
            end
          end
          if (last || (abort_q && mis)) begin
            state_d = FIN;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      swap_q  <= 1'b0;
      abort_q <= 1'b0;
      idx_q   <= '0;
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      fidx_q  <= '0;
      fgot_q  <= '0;
      fexp_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      swap_q  <= swap_d;
      abort_q <= abort_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      fidx_q  <= fidx_d;
      fgot_q  <= fgot_d;
      fexp_q  <= fexp_d;
    end
  end

endmodule

// File: tb/tb_stream_compare_monitor.sv
// Directed bench for stream_compare_monitor: reset, swap match,
// mismatches with/without abort, backpressure, start edges, saturation.
module tb_stream_compare_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] len;
  logic        swap;
  logic        abort_on_fail;
  logic [63:0] dut_out;
  logic        dut_out_isReady;
  logic        dut_out_canReceive;
  logic [63:0] exp_in;
  logic        exp_in_isReady;
  logic        exp_in_canReceive;
  logic        busy;
  logic        done;
  logic        fail;
  logic [23:0] mismatch_count;
  logic [23:0] first_idx;
  logic [63:0] first_got;
  logic [63:0] first_exp;

  logic        s_start;
  logic [3:0]  s_len;
  logic [63:0] s_dut;
  logic        s_dut_rdy;
  logic        s_dut_rcv;
  logic [63:0] s_exp;
  logic        s_exp_rdy;
  logic        s_exp_rcv;
  logic        s_busy;
  logic        s_done;
  logic        s_fail;
  logic [3:0]  s_cnt;
  logic [3:0]  s_fidx;
  logic [63:0] s_fgot;
  logic [63:0] s_fexp;

  int checks = 0;
  int errors = 0;

  logic [63:0] dw [16];
  logic [63:0] ew [16];
  int nxfer;
  bit got_done;
  bit done_ok;

  always #5 clk = ~clk;

  stream_compare_monitor u_dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .len                (len),
    .swap               (swap),
    .abort_on_fail      (abort_on_fail),
    .dut_out            (dut_out),
    .dut_out_isReady    (dut_out_isReady),
    .dut_out_canReceive (dut_out_canReceive),
    .exp_in             (exp_in),
    .exp_in_isReady     (exp_in_isReady),
    .exp_in_canReceive  (exp_in_canReceive),
    .busy               (busy),
    .done               (done),
    .fail               (fail),
    .mismatch_count     (mismatch_count),
    .first_idx          (first_idx),
    .first_got          (first_got),
    .first_exp          (first_exp)
  );

  stream_compare_monitor #(.WIDTH(64), .LEN_BITS(4)) u_sat (
    .clk                (clk),
    .rst                (rst),
    .start              (s_start),
    .len                (s_len),
    .swap               (1'b0),
    .abort_on_fail      (1'b0),
    .dut_out            (s_dut),
    .dut_out_isReady    (s_dut_rdy),
    .dut_out_canReceive (s_dut_rcv),
    .exp_in             (s_exp),
    .exp_in_isReady     (s_exp_rdy),
    .exp_in_canReceive  (s_exp_rcv),
    .busy               (s_busy),
    .done               (s_done),
    .fail               (s_fail),
    .mismatch_count     (s_cnt),
    .first_idx          (s_fidx),
    .first_got          (s_fgot),
    .first_exp          (s_fexp)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rev64(input logic [63:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24],
            x[39:32], x[47:40], x[55:48], x[63:56]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int n, input bit sw, input bit ab,
                            input bit gaps, input bit poke);
    int dp;
    int ep;
    int lock_err;
    bit xd;
    bit xe;
    bit prev_x;
    dp = 0;
    ep = 0;
    lock_err = 0;
    prev_x = 1'b0;
    nxfer = 0;
    got_done = 1'b0;
    done_ok = 1'b0;
    len = 24'(n);
    swap = sw;
    abort_on_fail = ab;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      if (done) begin
        got_done = 1'b1;
        done_ok = prev_x || (n == 0 && cyc == 0);
      end else begin
        dut_out_isReady = (dp < n) &&
          (!gaps || $urandom_range(0, 2) != 0);
        exp_in_isReady = (ep < n) &&
          (!gaps || $urandom_range(0, 2) != 0);
        dut_out = dw[dp % 16];
        exp_in  = ew[ep % 16];
        if (poke && cyc == 2) begin
          start = 1'b1;
          len = 24'd1;
        end else begin
          start = 1'b0;
        end
        #1;
        xd = dut_out_isReady && dut_out_canReceive;
        xe = exp_in_isReady && exp_in_canReceive;
        if (xd != xe) lock_err++;
        if (xd != (dut_out_isReady && exp_in_isReady)) lock_err++;
        prev_x = xd;
        @(posedge clk);
        #1;
        if (xd) nxfer++;
        if (xd) dp++;
        if (xe) ep++;
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(got_done), 64'd1);
    chk("done_latency", 64'(done_ok), 64'd1);
    chk("lockstep", 64'(lock_err), 64'd0);
    chk("busy_in_fin", 64'(busy), 64'd0);
    dut_out_isReady = 1'b1;
    exp_in_isReady = 1'b1;
    tick();
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_no_accept", 64'(dut_out_canReceive), 64'd0);
    chk("idle_no_accept_e", 64'(exp_in_canReceive), 64'd0);
    dut_out_isReady = 1'b0;
    exp_in_isReady = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    swap = 1'b0;
    abort_on_fail = 1'b0;
    dut_out = '0;
    exp_in = '0;
    dut_out_isReady = 1'b1;
    exp_in_isReady = 1'b1;
    s_start = 1'b0;
    s_len = '0;
    s_dut = '0;
    s_exp = '0;
    s_dut_rdy = 1'b0;
    s_exp_rdy = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_cnt", 64'(mismatch_count), 64'd0);
    chk("rst_rcv", 64'(dut_out_canReceive), 64'd0);

    // Test 1: reset mid-run after 3 transfers, word 1 mismatching
    for (int i = 0; i < 16; i++) begin
      dw[i] = 64'h1000 + 64'(i);
      ew[i] = dw[i];
    end
    ew[1] = 64'h00FF;
    rst = 1'b0;
    dut_out_isReady = 1'b0;
    exp_in_isReady = 1'b0;
    len = 24'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dut_out = dw[i];
      exp_in = ew[i];
      dut_out_isReady = 1'b1;
      exp_in_isReady = 1'b1;
      tick();
    end
    chk("t1_fail_before_rst", 64'(fail), 64'd1);
    chk("t1_cnt_before_rst", 64'(mismatch_count), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_fail", 64'(fail), 64'd0);
    chk("t1_cnt", 64'(mismatch_count), 64'd0);
    chk("t1_fidx", 64'(first_idx), 64'd0);
    chk("t1_fgot", first_got, 64'd0);
    chk("t1_fexp", first_exp, 64'd0);
    chk("t1_rcv_d", 64'(dut_out_canReceive), 64'd0);
    chk("t1_rcv_e", 64'(exp_in_canReceive), 64'd0);
    tick();
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_idle_rcv", 64'(dut_out_canReceive), 64'd0);
    dut_out_isReady = 1'b0;
    exp_in_isReady = 1'b0;

    // Test 2: swap match
    dw[0] = 64'h0123456789ABCDEF;
    ew[0] = 64'hEFCDAB8967452301;
    dw[1] = 64'h1122334455667788;
    ew[1] = 64'h8877665544332211;
    dw[2] = 64'hDEADBEEF00C0FFEE;
    ew[2] = rev64(dw[2]);
    dw[3] = 64'h0000000000000001;
    ew[3] = 64'h0100000000000000;
    run_stream(4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_xfers", 64'(nxfer), 64'd4);
    chk("t2_fail", 64'(fail), 64'd0);
    chk("t2_cnt", 64'(mismatch_count), 64'd0);

    // Test 5a: same data with random gaps and a start poke during RUN
    run_stream(4, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t5_xfers", 64'(nxfer), 64'd4);
    chk("t5_fail", 64'(fail), 64'd0);
    chk("t5_cnt", 64'(mismatch_count), 64'd0);

    // Test 3: mismatches at 5 and 9, no abort
    for (int i = 0; i < 16; i++) begin
      dw[i] = {32'hA5A50000, 32'(i)};
      ew[i] = dw[i];
    end
    ew[5] = 64'hA5A5000000000055;
    ew[9] = 64'h0;
    run_stream(16, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_xfers", 64'(nxfer), 64'd16);
    chk("t3_cnt", 64'(mismatch_count), 64'd2);
    chk("t3_fidx", 64'(first_idx), 64'd5);
    chk("t3_fgot", first_got, 64'hA5A5000000000005);
    chk("t3_fexp", first_exp, 64'hA5A5000000000055);
    chk("t3_fail", 64'(fail), 64'd1);

    // Test 4: same data, abort on first mismatch
    run_stream(16, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_xfers", 64'(nxfer), 64'd6);
    chk("t4_cnt", 64'(mismatch_count), 64'd1);
    chk("t4_fidx", 64'(first_idx), 64'd5);
    chk("t4_fail", 64'(fail), 64'd1);

    // Test 5b: len=0, results from the previous run get cleared
    run_stream(0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_len0_xfers", 64'(nxfer), 64'd0);
    chk("t5_len0_fail", 64'(fail), 64'd0);
    chk("t5_len0_cnt", 64'(mismatch_count), 64'd0);

    // Test 6: saturation with LEN_BITS=4
    begin
      int sx;
      bit sd;
      sx = 0;
      sd = 1'b0;
      s_len = 4'd15;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int cyc = 0; cyc < 40 && !sd; cyc++) begin
        if (s_done) begin
          sd = 1'b1;
        end else begin
          s_dut = 64'(sx);
          s_exp = ~64'(sx);
          s_dut_rdy = 1'b1;
          s_exp_rdy = 1'b1;
          #1;
          if (s_dut_rcv) sx++;
          tick();
        end
      end
      s_dut_rdy = 1'b0;
      s_exp_rdy = 1'b0;
      chk("t6_done", 64'(sd), 64'd1);
      chk("t6_xfers", 64'(sx), 64'd15);
      chk("t6_cnt", 64'(s_cnt), 64'd15);
      chk("t6_fidx", 64'(s_fidx), 64'd0);
      chk("t6_fail", 64'(s_fail), 64'd1);
      tick();
      chk("t6_hold_cnt", 64'(s_cnt), 64'd15);
      s_len = 4'd1;
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      chk("t6_clr_fail", 64'(s_fail), 64'd0);
      chk("t6_clr_cnt", 64'(s_cnt), 64'd0);
      chk("t6_rerun_busy", 64'(s_busy), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
